hazard_ctrl_unit: RTL and testbench

Parametrised pipeline hazard controller for the 5-stage RISC-V core; successor to the fixed load-use/store-stall detector.
- Sits between ID and EX. Drives PC write-enable, IF/ID write-enable, IF/ID flush and the ID/EX bubble (nop) mux.
- Adds configurable load-use and store stall lengths, x0 exclusion, per-operand use qualifiers, branch-flush priority, and an enable freeze.

---
 rtl/haz_pkg.sv | 26 ++
 rtl/haz_stall_counter.sv | 32 +++
 rtl/hazard_ctrl_unit.sv | 132 +++++++++++++
 tb/tb_hazard_ctrl_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/haz_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package haz_pkg;

    typedef enum logic [1:0] {
        RUN,
        LD_STALL,
        ST_STALL
    } haz_state_t;

    localparam int REG_X0 = 0;

    // Front-end control set; field order fixes the encoding of the constants below.
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_bubble;
    } haz_out_t;

    localparam haz_out_t OUT_RUN    = 4'b1100;
    localparam haz_out_t OUT_STALL  = 4'b0001;
    localparam haz_out_t OUT_FLUSH  = 4'b1111;
    localparam haz_out_t OUT_FREEZE = 4'b0000;
    localparam haz_out_t OUT_RESET  = 4'b0001;

endpackage

// File: rtl/haz_stall_counter.sv
// Loadable down-counter tracking the remaining stall cycles; done flags the last one.
module haz_stall_counter #(
    parameter int CNT_W = 3
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             enable,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block evaluation order.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
        end else if (enable) begin
            if (load) begin
                cnt <= load_val;
            end else if (dec) begin
                cnt <= cnt - 1'b1;
            end
        end
    end

    assign done = (cnt == CNT_W'(1));

endmodule

// File: rtl/hazard_ctrl_unit.sv
// ID/EX hazard controller: load-use and store stalls, branch flush, enable freeze.
// Optional HAZ_PERF_CNT_EN adds stall/flush performance counters.
module hazard_ctrl_unit
    import haz_pkg::*;
#(
    parameter int REG_AW          = 5,
    parameter int LOAD_USE_STALLS = 1,
    parameter int STORE_STALLS    = 2,
    parameter int CNT_W           = 3
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic [REG_AW-1:0] id_rs1,
    input  logic [REG_AW-1:0] id_rs2,
    input  logic              id_rs1_used,
    input  logic              id_rs2_used,
    input  logic [REG_AW-1:0] ex_rd,
    input  logic              ex_mem_read,
    input  logic              ex_reg_write,
    input  logic              ex_mem_write,
    input  logic              ex_branch_taken,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_bubble,
    output logic              stall_active
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [31:0]       perf_stall_cnt,
    output logic [31:0]       perf_flush_cnt
`endif
);

    haz_state_t       state, state_next;
    haz_out_t         out_set;
    logic             hazard_lu;
    logic             store_trig;
    logic             cnt_load;
    logic             cnt_dec;
    logic             cnt_done;
    logic [CNT_W-1:0] cnt_load_val;

    assign hazard_lu = enable && ex_mem_read && ex_reg_write
                       && (ex_rd != REG_AW'(REG_X0))
                       && ((id_rs1_used && (ex_rd == id_rs1))
                           || (id_rs2_used && (ex_rd == id_rs2)));

    // A load that is also flagged as a store follows the load-use rule only.
    assign store_trig = ex_mem_write && !ex_mem_read && (STORE_STALLS > 0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_next   = state;
        out_set      = OUT_RUN;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;

        if (reset) begin
            out_set    = OUT_RESET;
            state_next = RUN;
        end else if (!enable) begin
            out_set = OUT_FREEZE;
        end else if (ex_branch_taken) begin
            out_set    = OUT_FLUSH;
            state_next = RUN;
            cnt_load   = 1'b1;
        end else if (state != RUN) begin
            out_set = OUT_STALL;
            cnt_dec = 1'b1;
            if (cnt_done) begin
                state_next = RUN;
            end
        end else if (hazard_lu) begin
            out_set = OUT_STALL;
            if (LOAD_USE_STALLS > 1) begin
                state_next   = LD_STALL;
                cnt_load     = 1'b1;
                cnt_load_val = CNT_W'(LOAD_USE_STALLS - 1);
            end
        end else if (store_trig) begin
            state_next   = ST_STALL;
            cnt_load     = 1'b1;
            cnt_load_val = CNT_W'(STORE_STALLS);
        end
    end

    assign pc_write     = out_set.pc_write;
    assign if_id_write  = out_set.if_id_write;
    assign if_id_flush  = out_set.if_id_flush;
    assign id_ex_bubble = out_set.id_ex_bubble;
    assign stall_active = !reset && ((state != RUN) || hazard_lu);

    haz_stall_counter #(
        .CNT_W(CNT_W)
    ) u_stall_counter (
        .clock    (clock),
        .reset    (reset),
        .enable   (enable),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

`ifdef HAZ_PERF_CNT_EN
    always_ff @(posedge clock) begin
        if (reset) begin
            perf_stall_cnt <= '0;
            perf_flush_cnt <= '0;
        end else if (enable) begin
            if (id_ex_bubble && !if_id_flush) begin
                perf_stall_cnt <= perf_stall_cnt + 32'd1;
            end
            if (if_id_flush) begin
                perf_flush_cnt <= perf_flush_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_hazard_ctrl_unit.sv
// Scoreboard bench for hazard_ctrl_unit: two instances with different stall lengths
// share one stimulus stream and are checked against a stall-budget reference model.
module tb_hazard_ctrl_unit;

    localparam int REG_AW = 5;
    localparam int L_A = 1, S_A = 2;
    localparam int L_B = 3, S_B = 3;

    typedef struct packed {
        logic              reset;
        logic              enable;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic              u1;
        logic              u2;
        logic [REG_AW-1:0] rd;
        logic              mr;
        logic              rw;
        logic              mw;
        logic              br;
    } stim_t;

    // core bits: {pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active}
    typedef struct packed {
        logic [1:0][4:0]  core;
        logic [1:0][31:0] ps;
        logic [1:0][31:0] pf;
    } exp_t;

    logic              clock;
    logic              reset;
    logic              enable;
    logic [REG_AW-1:0] id_rs1, id_rs2, ex_rd;
    logic              id_rs1_used, id_rs2_used;
    logic              ex_mem_read, ex_reg_write, ex_mem_write, ex_branch_taken;
    logic [1:0]        pc_write, if_id_write, if_id_flush, id_ex_bubble, stall_active;
`ifdef HAZ_PERF_CNT_EN
    logic [31:0]       perf_stall_cnt [2];
    logic [31:0]       perf_flush_cnt [2];
`endif

    exp_t        exp_q[$];
    int          n_checks = 0;
    int          n_errors = 0;
    int          stall_left [2];
    logic [31:0] m_pstall [2];
    logic [31:0] m_pflush [2];

    hazard_ctrl_unit #(
        .REG_AW(REG_AW), .LOAD_USE_STALLS(L_A), .STORE_STALLS(S_A), .CNT_W(3)
    ) dut_a (
        .clock(clock), .reset(reset), .enable(enable),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write[0]), .if_id_write(if_id_write[0]),
        .if_id_flush(if_id_flush[0]), .id_ex_bubble(id_ex_bubble[0]),
        .stall_active(stall_active[0])
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt[0]), .perf_flush_cnt(perf_flush_cnt[0])
`endif
    );

    hazard_ctrl_unit #(
        .REG_AW(REG_AW), .LOAD_USE_STALLS(L_B), .STORE_STALLS(S_B), .CNT_W(3)
    ) dut_b (
        .clock(clock), .reset(reset), .enable(enable),
        .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used),
        .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_reg_write(ex_reg_write),
        .ex_mem_write(ex_mem_write), .ex_branch_taken(ex_branch_taken),
        .pc_write(pc_write[1]), .if_id_write(if_id_write[1]),
        .if_id_flush(if_id_flush[1]), .id_ex_bubble(id_ex_bubble[1]),
        .stall_active(stall_active[1])
`ifdef HAZ_PERF_CNT_EN
        , .perf_stall_cnt(perf_stall_cnt[1]), .perf_flush_cnt(perf_flush_cnt[1])
`endif
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // Reference model: stall_left is the number of stall cycles still owed after this one.
    task automatic model(input int k, input stim_t s, output logic [4:0] o);
        int   lu_len, st_len;
        logic hz;
        lu_len = (k == 0) ? L_A : L_B;
        st_len = (k == 0) ? S_A : S_B;
        hz = s.enable && s.mr && s.rw && (s.rd != 0)
             && ((s.u1 && s.rd == s.rs1) || (s.u2 && s.rd == s.rs2));
        if (s.reset) begin
            o = 5'b00010;
            stall_left[k] = 0;
            m_pstall[k] = 0;
            m_pflush[k] = 0;
        end else if (!s.enable) begin
            o = {4'b0000, stall_left[k] > 0};
        end else begin
            if (s.br) begin
                o = {4'b1111, (stall_left[k] > 0) || hz};
                stall_left[k] = 0;
            end else if (stall_left[k] > 0) begin
                o = 5'b00011;
                stall_left[k]--;
            end else if (hz) begin
                o = 5'b00011;
                stall_left[k] = lu_len - 1;
            end else begin
                o = 5'b11000;
                if (s.mw && !s.mr) stall_left[k] = st_len;
            end
            if (o[1] && !o[2]) m_pstall[k]++;
            if (o[2]) m_pflush[k]++;
        end
    endtask

    task automatic cyc(input stim_t s);
        exp_t e;
        @(posedge clock);
        #1;
        reset = s.reset; enable = s.enable;
        id_rs1 = s.rs1; id_rs2 = s.rs2; id_rs1_used = s.u1; id_rs2_used = s.u2;
        ex_rd = s.rd; ex_mem_read = s.mr; ex_reg_write = s.rw;
        ex_mem_write = s.mw; ex_branch_taken = s.br;
        for (int k = 0; k < 2; k++) begin
            e.ps[k] = m_pstall[k];
            e.pf[k] = m_pflush[k];
            model(k, s, e.core[k]);
        end
        exp_q.push_back(e);
    endtask

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        s.enable = 1'b1;
        return s;
    endfunction

    task automatic idles(input int n);
        for (int i = 0; i < n; i++) cyc(idle());
    endtask

    // Monitor: compares every presented cycle against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                for (int k = 0; k < 2; k++) begin
                    check(k == 0 ? "ctrl_a" : "ctrl_b",
                          32'({pc_write[k], if_id_write[k], if_id_flush[k],
                               id_ex_bubble[k], stall_active[k]}),
                          32'(e.core[k]));
`ifdef HAZ_PERF_CNT_EN
                    check(k == 0 ? "perf_stall_a" : "perf_stall_b", perf_stall_cnt[k], e.ps[k]);
                    check(k == 0 ? "perf_flush_a" : "perf_flush_b", perf_flush_cnt[k], e.pf[k]);
`endif
                end
            end
        end
    end

    initial begin
        stim_t s;
        reset = 1'b1; enable = 1'b1;
        id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
        ex_rd = '0; ex_mem_read = 1'b0; ex_reg_write = 1'b0;
        ex_mem_write = 1'b0; ex_branch_taken = 1'b0;
        for (int k = 0; k < 2; k++) begin
            stall_left[k] = 0; m_pstall[k] = 0; m_pflush[k] = 0;
        end

        s = idle(); s.reset = 1'b1;
        cyc(s); cyc(s);
        idles(2);

        // Load x5 in EX with rs1=x5 consumer.
        s = idle(); s.mr = 1; s.rw = 1; s.rd = 5; s.rs1 = 5; s.u1 = 1;
        cyc(s); idles(4);
        // Load writing x0 with rs1=x0 consumer.
        s = idle(); s.mr = 1; s.rw = 1; s.rd = 0; s.rs1 = 0; s.u1 = 1;
        cyc(s); idles(1);
        // rs2 match but rs2 not used.
        s = idle(); s.mr = 1; s.rw = 1; s.rd = 7; s.rs2 = 7; s.u2 = 0; s.rs1 = 3; s.u1 = 1;
        cyc(s); idles(1);
        // rs2 match with rs2 used.
        s.u2 = 1;
        cyc(s); idles(4);
        // Store in EX.
        s = idle(); s.mw = 1;
        cyc(s); idles(5);
        // Store stall cancelled by a taken branch.
        cyc(s);
        s = idle(); s.br = 1;
        cyc(s); idles(3);
        // Store stall aborted by reset.
        s = idle(); s.mw = 1;
        cyc(s); idles(1);
        s = idle(); s.reset = 1;
        cyc(s); idles(4);
        // Load-use then a three-cycle freeze inside the stall.
        s = idle(); s.mr = 1; s.rw = 1; s.rd = 9; s.rs1 = 9; s.u1 = 1;
        cyc(s);
        s = idle(); s.enable = 0;
        cyc(s); cyc(s); cyc(s);
        idles(4);
        // Load and store flags together: no store stall, load-use still applies.
        s = idle(); s.mr = 1; s.mw = 1; s.rw = 1; s.rd = 4; s.rs1 = 2; s.u1 = 1;
        cyc(s); idles(4);
        s.rs1 = 4;
        cyc(s); idles(4);

        for (int i = 0; i < 3000; i++) begin
            s = idle();
            s.reset  = ($urandom_range(0, 99) < 2);
            s.enable = ($urandom_range(0, 99) < 85);
            s.rs1    = REG_AW'($urandom_range(0, 3));
            s.rs2    = REG_AW'($urandom_range(0, 3));
            s.rd     = REG_AW'($urandom_range(0, 3));
            s.u1     = 1'($urandom_range(0, 1));
            s.u2     = 1'($urandom_range(0, 1));
            s.mr     = ($urandom_range(0, 99) < 35);
            s.rw     = ($urandom_range(0, 99) < 75);
            s.mw     = ($urandom_range(0, 99) < 25);
            s.br     = ($urandom_range(0, 99) < 8);
            cyc(s);
        end

        repeat (2) @(negedge clock);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
